// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the credit-based push side of the CDC FIFO.
// Holds the push FSM encoding and the credit counter width helper.
package cdc_fifo_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    WAIT_RCV = 2'd1,
    ACTIVE   = 2'd2
  } push_state_e;

  // Counter must be able to hold MAX_CREDITS itself, hence the +1.
  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  localparam int DEFAULT_MAX_CREDITS  = 16;
  localparam int DEFAULT_CREDIT_WIDTH = credit_width(DEFAULT_MAX_CREDITS);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Purely combinational; the owner advances the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  always_comb begin
    int idx;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!found && request_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_push_arbiter.sv
// Multiplexes NUM_REQ requesters onto one credit-flow-controlled push port.
// Handles the sender/receiver reset handshake and tracks downstream credits.
module credit_push_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  DATA_WIDTH   = 8,
  parameter int  MAX_CREDITS  = 16,
  localparam int CREDIT_WIDTH = credit_width(MAX_CREDITS),
  localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          push_clk,
  input  logic                          push_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [CREDIT_WIDTH-1:0]       credit_initial,
  input  logic [CREDIT_WIDTH-1:0]       credit_withhold,
  input  logic                          push_credit,
  input  logic                          push_receiver_in_reset,
  output logic                          push_sender_in_reset,
  output logic                          push_credit_stall,
  output logic                          push_valid,
  output logic [DATA_WIDTH-1:0]         push_data,
  output logic [CREDIT_WIDTH-1:0]       credit_count,
  output logic [CREDIT_WIDTH-1:0]       credit_available,
  output logic                          credit_overflow
);

  localparam int CW1 = CREDIT_WIDTH + 1;

  push_state_e             state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    push_valid_q;
  logic [DATA_WIDTH-1:0]   push_data_q, push_data_d;
  logic                    overflow_q, overflow_d;

  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      grant;
  logic                    grant_en;
  logic                    transfer;
  logic [PTR_W-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic [CW1-1:0]          credit_sum;

  assign credit_available = (credit_q > credit_withhold) ? (credit_q - credit_withhold) : '0;

  // The cycle the receiver enters reset must not grant, so it gates here too.
  assign grant_en = !push_rst && (state_q == ACTIVE) && !push_receiver_in_reset
                    && (credit_available != '0);
  assign arb_req  = req_valid & {NUM_REQ{grant_en}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr (
    .request_i (arb_req),
    .ptr_i     (ptr_q),
    .grant_o   (grant)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = PTR_W'(i);
        grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    ptr_d                = ptr_q;
    push_data_d          = push_data_q;
    credit_d             = credit_q;
    overflow_d           = overflow_q;
    push_sender_in_reset = 1'b0;
    push_credit_stall    = 1'b0;
    credit_sum           = {1'b0, credit_q} + CW1'(push_credit) - CW1'(transfer);

    case (state_q)
      INIT: begin
        push_sender_in_reset = 1'b1;
        push_credit_stall    = 1'b1;
        state_d              = WAIT_RCV;
      end
      WAIT_RCV: if (!push_receiver_in_reset) state_d = ACTIVE;
      ACTIVE:   if (push_receiver_in_reset)  state_d = INIT;
      default:  state_d = INIT;
    endcase

    // Reload wins over any credit return while initialising.
    if (state_q == INIT) begin
      credit_d = credit_initial;
    end else if (credit_sum > CW1'(MAX_CREDITS)) begin
      credit_d   = CREDIT_WIDTH'(MAX_CREDITS);
      overflow_d = 1'b1;
    end else begin
      credit_d = credit_sum[CREDIT_WIDTH-1:0];
    end

    if (transfer) begin
      push_data_d = grant_data;
      ptr_d       = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge push_clk) begin
    if (push_rst) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      credit_q     <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      push_valid_q <= transfer;
      push_data_q  <= push_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign push_valid      = push_valid_q;
  assign push_data       = push_data_q;
  assign credit_count    = credit_q;
  assign credit_overflow = overflow_q;

endmodule

// File: tb/tb_credit_push_arbiter.sv
// Randomised and directed bench for credit_push_arbiter against a
// cycle-level behavioural model of the push-side credit protocol.
module tb_credit_push_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MAX = 16;
  localparam int CW  = 5;

  localparam int PH_INIT   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_ACTIVE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid;
  logic [N*DW-1:0] data;
  logic [N-1:0]  ready;
  logic [CW-1:0] cinit, wh;
  logic          pc, rcv;
  logic          sender_rst, stall, pv;
  logic [DW-1:0] pd;
  logic [CW-1:0] count, avail;
  logic          ovf;

  credit_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_CREDITS(MAX)) dut (
    .push_clk               (clk),
    .push_rst               (rst),
    .req_valid              (valid),
    .req_data               (data),
    .req_ready              (ready),
    .credit_initial         (cinit),
    .credit_withhold        (wh),
    .push_credit            (pc),
    .push_receiver_in_reset (rcv),
    .push_sender_in_reset   (sender_rst),
    .push_credit_stall      (stall),
    .push_valid             (pv),
    .push_data              (pd),
    .credit_count           (count),
    .credit_available       (avail),
    .credit_overflow        (ovf)
  );

  always #5 clk = ~clk;

  int m_phase, m_ptr, m_count, m_pv, m_pd, m_ovf;
  int passed = 0;
  int total  = 0;
  int order [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int exp_avail();
    return (m_count > int'(wh)) ? m_count - int'(wh) : 0;
  endfunction

  // Index of the requester that must be granted, or -1 for none.
  function automatic int exp_grant();
    if (rst || m_phase != PH_ACTIVE || rcv || exp_avail() == 0) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic compare_all();
    int g;
    g = exp_grant();
    chk("req_ready", int'(ready), (g < 0) ? 0 : (1 << g));
    chk("push_valid", int'(pv), m_pv);
    if (m_pv != 0) chk("push_data", int'(pd), m_pd);
    chk("credit_count", int'(count), m_count);
    chk("credit_available", int'(avail), exp_avail());
    chk("credit_overflow", int'(ovf), m_ovf);
    chk("sender_in_reset", int'(sender_rst), (m_phase == PH_INIT) ? 1 : 0);
    chk("credit_stall", int'(stall), (m_phase == PH_INIT) ? 1 : 0);
  endtask

  // Inputs are already applied; check, then advance model over one clock edge.
  task automatic step();
    int g, n_phase, n_ptr, n_count, n_pv, n_pd, n_ovf;
    #1;
    compare_all();
    g = exp_grant();
    n_phase = m_phase; n_ptr = m_ptr; n_count = m_count;
    n_pv = 0; n_pd = m_pd; n_ovf = m_ovf;
    if (rst) begin
      n_phase = PH_INIT; n_ptr = 0; n_count = 0; n_pd = 0; n_ovf = 0;
    end else begin
      if (g >= 0) begin
        n_pv  = 1;
        n_pd  = int'(data[g*DW +: DW]);
        n_ptr = (g + 1) % N;
      end
      if (m_phase == PH_INIT) n_phase = PH_WAIT;
      else if (m_phase == PH_WAIT && !rcv) n_phase = PH_ACTIVE;
      else if (m_phase == PH_ACTIVE && rcv) n_phase = PH_INIT;
      if (m_phase == PH_INIT) n_count = int'(cinit);
      else begin
        n_count = m_count + int'(pc) - ((g >= 0) ? 1 : 0);
        if (n_count > MAX) begin
          n_count = MAX;
          n_ovf   = 1;
        end
      end
    end
    @(posedge clk);
    m_phase = n_phase; m_ptr = n_ptr; m_count = n_count;
    m_pv = n_pv; m_pd = n_pd; m_ovf = n_ovf;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; valid = '0; data = '0; cinit = 5'd16; wh = 5'd4; pc = 1'b0; rcv = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_phase = PH_INIT; m_ptr = 0; m_count = 0; m_pv = 0; m_pd = 0; m_ovf = 0;
    step();
    chk("reset_count", int'(count), 0);
    chk("reset_ready", int'(ready), 0);

    // Bring-up with the receiver held in reset for five cycles.
    rst = 1'b0; valid = 4'hF; data = $urandom;
    #1;
    chk("init_sender_rst", int'(sender_rst), 1);
    chk("init_stall", int'(stall), 1);
    step();
    chk("bringup_count", int'(count), 16);
    chk("bringup_avail", int'(avail), 12);
    chk("bringup_sender_rst", int'(sender_rst), 0);
    repeat (4) begin
      chk("bringup_no_grant", int'(ready), 0);
      step();
    end
    rcv = 1'b0;
    #1 chk("wait_no_grant", int'(ready), 0);
    step();

    // Exhaustion: all requesters valid, no returns.
    for (int c = 0; c < 20; c++) begin
      data = {$urandom};
      #1;
      for (int i = 0; i < N; i++)
        if (ready[i]) begin
          $display("xfer %0d req %0d data 0x%02h", order.size(), i, data[i*DW +: DW]);
          order.push_back(i);
        end
      step();
    end
    chk("exhaust_transfers", order.size(), 12);
    for (int k = 0; k < order.size() && k < 12; k++) chk("exhaust_order", order[k], k % 4);
    chk("exhaust_count", int'(count), 4);
    #1 chk("exhaust_ready", int'(ready), 0);

    // Simultaneous return and transfer at count 5.
    valid = '0; pc = 1'b1;
    step();
    chk("simul_pre_count", int'(count), 5);
    valid = 4'b0001;
    #1 chk("simul_grant", int'(ready), 1);
    step();
    chk("simul_count", int'(count), 5);
    chk("simul_push_valid", int'(pv), 1);

    // Dynamic withhold at count 10.
    valid = '0;
    repeat (5) step();
    chk("withhold_count", int'(count), 10);
    pc = 1'b0; valid = 4'hF;
    #1 chk("withhold_low_grant", int'(ready), 4'b0010);
    wh = 5'd10;
    #1 chk("withhold_high_grant", int'(ready), 0);
    step();
    valid = '0; wh = 5'd4;

    // Overflow at full count.
    pc = 1'b1;
    repeat (6) step();
    chk("ovf_full_count", int'(count), 16);
    chk("ovf_before", int'(ovf), 0);
    step();
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(ovf), 1);
    pc = 1'b0;
    repeat (3) step();
    chk("ovf_sticky", int'(ovf), 1);

    // Receiver reset during traffic.
    cinit = 5'd9; valid = 4'hF;
    step();
    rcv = 1'b1;
    #1 chk("rcvrst_no_grant", int'(ready), 0);
    step();
    rcv = 1'b0;
    #1 chk("rcvrst_init", int'(sender_rst), 1);
    step();
    chk("rcvrst_reload", int'(count), 9);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      rcv   = ($urandom_range(0, 39) == 0);
      valid = N'($urandom);
      data  = {$urandom};
      pc    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) wh = CW'($urandom_range(0, 18));
      if ($urandom_range(0, 15) == 0) cinit = CW'($urandom_range(0, 16));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
